// File: rtl/b_to_o_pulse.sv
// b_to_o_pulse: accepts a 3-bit binary code and drives the matching one-hot
// line of an 8-bit output for PULSE_LEN cycles. It then forces GAP_LEN idle
// cycles before it accepts the next code.
//
// Handshake: a transfer happens at a rising edge where b_valid && b_ready.
// b_ready is a decode of the registered state only (high in IDLE), so it never
// depends combinationally on b_valid. The source holds b_valid/b until then.
// b_valid seen outside IDLE is ignored; nothing is queued.
module b_to_o_pulse #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_valid,
    input  logic [2:0] b,
    output logic       b_ready,
    output logic [7:0] o,
    output logic       o_valid,
    output logic       busy,
    output logic [1:0] dbg_state
);

    // Reject illegal lengths when the design is elaborated
    generate
        if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
            $error("b_to_o_pulse: PULSE_LEN must be within 1..255");
        end
        if (GAP_LEN < 0 || GAP_LEN > 255) begin : g_bad_gap_len
            $error("b_to_o_pulse: GAP_LEN must be within 0..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counter reload values. With no gap, the gap load value is never used.
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LOAD   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] o_nxt;
    logic       o_valid_nxt;
    logic       busy_nxt;

    // State and all visible outputs are registered, so o, o_valid and busy
    // come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            o       <= 8'h00;
            o_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            o       <= o_nxt;
            o_valid <= o_valid_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next-state logic. The registered outputs hold unless a transition
    // changes them.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        o_nxt       = o;
        o_valid_nxt = o_valid;
        case (state)
            IDLE: begin
                if (b_valid) begin
                    state_nxt   = DRIVE;
                    cnt_nxt     = PULSE_LOAD;
                    o_nxt       = 8'b0000_0001 << b;
                    o_valid_nxt = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == 8'd0) begin
                    o_nxt       = 8'h00;
                    o_valid_nxt = 1'b0;
                    if (GAP_LEN > 0) begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = 8'd0;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = 8'd0;
                o_nxt       = 8'h00;
                o_valid_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    assign b_ready   = (state == IDLE);
    assign dbg_state = state;

endmodule

// File: doc/b_to_o_pulse.md
B_TO_O_PULSE -- requirements
Module: b_to_o_pulse

Interface
REQ-001 Parameter PULSE_LEN, default 4: number of cycles each decoded output line is held high; legal range 1..255.
REQ-002 Parameter GAP_LEN, default 1: number of idle cycles forced after each pulse; legal range 0..255.
REQ-003 Out-of-range PULSE_LEN or GAP_LEN SHALL fail elaboration.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 b_valid  input  1  source offers a 3-bit binary code on b.
REQ-007 b  input  3  binary code 0..7 to decode.
REQ-008 b_ready  output  1  block accepts a code this cycle.
REQ-009 o  output  8  one-hot octal line; bit o[k] corresponds to code k.
REQ-010 o_valid  output  1  high exactly while o is non-zero (pulse active).
REQ-011 busy  output  1  high in DRIVE or GAP state.

Function
REQ-012 The FSM SHALL have states IDLE, DRIVE and GAP, plus an 8-bit down-counter cnt.
REQ-013 b_ready SHALL equal (state == IDLE) and SHALL depend only on registered state, never combinationally on b_valid.
REQ-014 A transfer occurs at a rising edge where b_valid and b_ready are both high; b is sampled only at that edge.
REQ-015 On a transfer, the block SHALL enter DRIVE, set o to 8'b1 << b, set o_valid to 1, and load cnt with PULSE_LEN-1, all on that same edge.
REQ-016 Latency: o SHALL become one-hot in the first cycle after the accepting edge.
REQ-017 In DRIVE, cnt SHALL decrement once per cycle, and o SHALL hold its value unchanged.
REQ-018 When cnt == 0 in DRIVE, the block SHALL leave DRIVE on the next edge; the pulse is therefore exactly PULSE_LEN cycles long.
REQ-019 On leaving DRIVE with GAP_LEN > 0, the block SHALL enter GAP, load cnt with GAP_LEN-1, and clear o and o_valid.
REQ-020 On leaving DRIVE with GAP_LEN == 0, the block SHALL enter IDLE directly and clear o and o_valid.
REQ-021 In GAP, cnt SHALL decrement once per cycle; at cnt == 0 the block SHALL enter IDLE on the next edge.
REQ-022 The minimum spacing between accepting edges is PULSE_LEN + GAP_LEN + 1 cycles.
REQ-023 b_valid asserted outside IDLE SHALL be ignored; no code is queued.
REQ-024 The source SHALL hold b_valid and b stable until the transfer occurs.
REQ-025 In IDLE and GAP, o SHALL be 8'h00 and o_valid SHALL be 0.
REQ-026 In DRIVE, o SHALL have exactly one bit set.
REQ-027 Any change of b while the block is not in IDLE SHALL have no effect on o.
REQ-028 Every output (o, o_valid, busy) SHALL be driven directly from a flop.
REQ-029 The values 0 and 7 for b are ordinary codes with no special behaviour.

Reset
REQ-030 Asserting rst SHALL immediately, without waiting for a clock edge, force state = IDLE, cnt = 0, o = 8'h00, o_valid = 0, busy = 0 and b_ready = 1.
REQ-031 Reset asserted mid-pulse or mid-gap SHALL abort the pulse; no partial pulse resumes after release.
REQ-032 The first transfer after reset release SHALL be possible at the first rising edge on which rst is low.

Verification
REQ-033 Defaults, b=3'd5 with b_valid for 1 cycle: o = 8'h20 for exactly 4 cycles starting one cycle after the accepting edge, then 1 gap cycle, then b_ready = 1.
REQ-034 Sweep b = 0..7, each held until b_ready: o[k] is the only bit high, pulses o = 8'h01, 8'h02, ..., 8'h80, and accepting edges are 6 cycles apart.
REQ-035 b_valid held high with b changing 3->6 during DRIVE: o stays 8'h08 for the whole pulse, and 6 is accepted only at the next IDLE cycle.
REQ-036 PULSE_LEN = 1, GAP_LEN = 0, b_valid held high with b = 3'd2: o = 8'h04 on alternate cycles, and o_valid toggles every cycle.
REQ-037 rst asserted asynchronously in the 2nd cycle of a b = 3'd7 pulse: o = 0 and b_ready = 1 immediately; after release, b = 3'd1 yields a full 4-cycle 8'h02 pulse.
REQ-038 The bench SHALL check continuously that o_valid == (o != 0), that o is one-hot in DRIVE, and that b_ready == !busy.
